// File: rtl/stq_fwd.sv
// stq_fwd: store queue with store-to-load forwarding.
// Stores are allocated in program order, have their address/data filled by
// direct index from the AGU, and drain to the data cache one at a time once
// the head store reaches the ROB head. NUM_LD load probes are resolved
// combinationally against the stores that were older than each load.
module stq_fwd #(
    parameter int DEPTH    = 8,
    parameter int ROB_ID_W = 5,
    parameter int NUM_LD   = 2,
    localparam int IDX     = $clog2(DEPTH),
    localparam int PW      = IDX + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    // dispatch
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [ROB_ID_W-1:0]    enq_rob_id,
    output logic [PW-1:0]          enq_stq_idx,
    // AGU fill
    input  logic                   agu_valid,
    input  logic [IDX-1:0]         agu_idx,
    input  logic [31:0]            agu_addr,
    input  logic [3:0]             agu_mask,
    input  logic [31:0]            agu_wdata,
    // ROB / data cache
    input  logic [ROB_ID_W-1:0]    rob_head_id,
    output logic                   dmem_valid,
    input  logic                   dmem_ready,
    output logic [31:0]            dmem_addr,
    output logic [3:0]             dmem_wmask,
    output logic [31:0]            dmem_wdata,
    output logic                   done_valid,
    output logic [ROB_ID_W-1:0]    done_rob_id,
    output logic [PW-1:0]          count,
    // load probes
    input  logic [NUM_LD-1:0]      ld_valid,
    input  logic [NUM_LD*32-1:0]   ld_addr,
    input  logic [NUM_LD*4-1:0]    ld_mask,
    input  logic [NUM_LD*PW-1:0]   ld_tail,
    output logic [NUM_LD-1:0]      fwd_hit,
    output logic [NUM_LD-1:0]      fwd_stall,
    output logic [NUM_LD*32-1:0]   fwd_data
);

    // Pointers carry a wrap flag in the MSB so full and empty are distinct.
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [PW-1:0]        count_reg;

    // Entry storage. Kept in flops: every entry is read in parallel by the probes.
    logic [ROB_ID_W-1:0]  rob_id_reg [DEPTH];
    logic [DEPTH-1:0]     addr_valid_reg;
    logic [31:2]          addr_reg   [DEPTH];
    logic [3:0]           mask_reg   [DEPTH];
    logic [31:0]          wdata_reg  [DEPTH];

    logic                 empty;
    logic                 full;
    logic                 enq_fire;
    logic                 deq_fire;
    logic                 drain_want;
    logic                 agu_fire;
    logic [IDX-1:0]       wr_idx;
    logic [IDX-1:0]       head_idx;
    logic [IDX-1:0]       agu_off;
    logic                 agu_occupied;

    // Byte offset of the store address never reaches the queue.
    logic                 unused_agu_lo;
    assign unused_agu_lo = ^agu_addr[1:0];

    assign wr_idx   = wr_ptr_reg[IDX-1:0];
    assign head_idx = rd_ptr_reg[IDX-1:0];
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[IDX-1:0] == rd_ptr_reg[IDX-1:0]) &&
                      (wr_ptr_reg[IDX] != rd_ptr_reg[IDX]);

    assign enq_ready = ~full;
    assign enq_fire  = enq_valid & ~full;

    // A fill only lands on a live entry; a same-cycle allocation of that slot wins.
    assign agu_off      = agu_idx - head_idx;
    assign agu_occupied = ({1'b0, agu_off} < count_reg);
    assign agu_fire     = agu_valid & agu_occupied & ~(enq_fire && (agu_idx == wr_idx));

    // Head drains once its address is known and the ROB has reached it.
    assign drain_want = ~empty & addr_valid_reg[head_idx] & (rob_id_reg[head_idx] == rob_head_id);
    assign deq_fire   = drain_want & dmem_ready;

    assign dmem_valid  = drain_want;
    assign dmem_addr   = {addr_reg[head_idx], 2'b00};
    assign dmem_wmask  = mask_reg[head_idx];
    assign dmem_wdata  = wdata_reg[head_idx];
    assign done_valid  = deq_fire;
    assign done_rob_id = rob_id_reg[head_idx];
    assign enq_stq_idx = wr_ptr_reg;
    assign count       = count_reg;

    // Pointer and occupancy update; flush discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + PW'(enq_fire) - PW'(deq_fire);
        end
    end

    // Address-known flags: cleared on allocation, set by an accepted fill.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            addr_valid_reg <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (enq_fire && (wr_idx == IDX'(e))) begin
                    addr_valid_reg[e] <= 1'b0;
                end else if (agu_fire && (agu_idx == IDX'(e))) begin
                    addr_valid_reg[e] <= 1'b1;
                end
            end
        end
    end

    // Payload fields need no reset; they are only consulted when addr_valid is set.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            rob_id_reg[wr_idx] <= enq_rob_id;
        end
        if (agu_fire) begin
            addr_reg[agu_idx]  <= agu_addr[31:2];
            mask_reg[agu_idx]  <= agu_mask;
            wdata_reg[agu_idx] <= agu_wdata;
        end
    end

    // One probe resolver per load channel.
    generate
        for (genvar gi = 0; gi < NUM_LD; gi++) begin : g_probe
            logic [31:0]    p_addr;
            logic [3:0]     p_mask;
            logic [PW-1:0]  p_tail;
            logic [PW-1:0]  n_raw;
            logic [PW-1:0]  n_eff;
            logic [IDX-1:0] e_idx;
            logic           unknown;
            logic           found;
            logic [3:0]     m_mask;
            logic [31:0]    m_data;
            logic           hit;
            logic           stall;
            logic [31:0]    data;
            logic           unused_ld_lo;

            assign p_addr       = ld_addr[gi*32 +: 32];
            assign p_mask       = ld_mask[gi*4 +: 4];
            assign p_tail       = ld_tail[gi*PW +: PW];
            assign unused_ld_lo = ^p_addr[1:0];

            // Scan older stores oldest-to-youngest so the last match is the youngest.
            always_comb begin
                hit     = 1'b0;
                stall   = 1'b0;
                data    = '0;
                unknown = 1'b0;
                found   = 1'b0;
                m_mask  = '0;
                m_data  = '0;
                e_idx   = '0;
                n_raw   = p_tail - rd_ptr_reg;
                // A tail behind the head means every older store has already drained.
                n_eff   = (n_raw > count_reg) ? '0 : n_raw;
                for (int k = 0; k < DEPTH; k++) begin
                    e_idx = head_idx + IDX'(k);
                    if (PW'(k) < n_eff) begin
                        if (!addr_valid_reg[e_idx]) begin
                            unknown = 1'b1;
                        end else if (addr_reg[e_idx] == p_addr[31:2]) begin
                            found  = 1'b1;
                            m_mask = mask_reg[e_idx];
                            m_data = wdata_reg[e_idx];
                        end
                    end
                end
                if (ld_valid[gi]) begin
                    if (unknown) begin
                        stall = 1'b1;
                    end else if (found) begin
                        if ((m_mask & p_mask) == p_mask) begin
                            hit  = 1'b1;
                            data = m_data;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
            end

            assign fwd_hit[gi]           = hit;
            assign fwd_stall[gi]         = stall;
            assign fwd_data[gi*32 +: 32] = data;
        end
    endgenerate

endmodule

// File: tb/tb_stq_fwd.sv
// Directed testbench for stq_fwd: reset, fill-to-full drain, pointer wrap,
// forwarding hit/stall cases, tail semantics and flush.
module tb_stq_fwd;

    localparam int DEPTH = 8;
    localparam int RW    = 5;
    localparam int NL    = 2;
    localparam int IDX   = 3;
    localparam int PW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [RW-1:0]     enq_rob_id;
    logic [PW-1:0]     enq_stq_idx;
    logic              agu_valid;
    logic [IDX-1:0]    agu_idx;
    logic [31:0]       agu_addr;
    logic [3:0]        agu_mask;
    logic [31:0]       agu_wdata;
    logic [RW-1:0]     rob_head_id;
    logic              dmem_valid;
    logic              dmem_ready;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic              done_valid;
    logic [RW-1:0]     done_rob_id;
    logic [PW-1:0]     count;
    logic [NL-1:0]     ld_valid;
    logic [NL*32-1:0]  ld_addr;
    logic [NL*4-1:0]   ld_mask;
    logic [NL*PW-1:0]  ld_tail;
    logic [NL-1:0]     fwd_hit;
    logic [NL-1:0]     fwd_stall;
    logic [NL*32-1:0]  fwd_data;

    int tests_run    = 0;
    int tests_failed = 0;

    stq_fwd #(.DEPTH(DEPTH), .ROB_ID_W(RW), .NUM_LD(NL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rob_id(enq_rob_id),
        .enq_stq_idx(enq_stq_idx),
        .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr),
        .agu_mask(agu_mask), .agu_wdata(agu_wdata),
        .rob_head_id(rob_head_id),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .done_valid(done_valid), .done_rob_id(done_rob_id), .count(count),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_tail(ld_tail),
        .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_enq(input logic [RW-1:0] rob);
        enq_valid  = 1'b1;
        enq_rob_id = rob;
        tick();
        enq_valid  = 1'b0;
    endtask

    task automatic do_fill(input logic [IDX-1:0] idx, input logic [31:0] a,
                           input logic [3:0] m, input logic [31:0] d);
        agu_valid = 1'b1;
        agu_idx   = idx;
        agu_addr  = a;
        agu_mask  = m;
        agu_wdata = d;
        tick();
        agu_valid = 1'b0;
    endtask

    task automatic set_ld(input int ch, input logic [31:0] a, input logic [3:0] m,
                          input logic [PW-1:0] t);
        ld_valid[ch]           = 1'b1;
        ld_addr[ch*32 +: 32]   = a;
        ld_mask[ch*4 +: 4]     = m;
        ld_tail[ch*PW +: PW]   = t;
        #1;
    endtask

    task automatic chk_probe(input string tag, input int ch, input logic h,
                             input logic s, input logic [31:0] d);
        check_eq({tag, "_hit"},   32'(fwd_hit[ch]),       32'(h));
        check_eq({tag, "_stall"}, 32'(fwd_stall[ch]),     32'(s));
        check_eq({tag, "_data"},  fwd_data[ch*32 +: 32],  d);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        enq_valid = 1'b0; enq_rob_id = '0;
        agu_valid = 1'b0; agu_idx = '0; agu_addr = '0; agu_mask = '0; agu_wdata = '0;
        rob_head_id = 5'd31; dmem_ready = 1'b0;
        ld_valid = '0; ld_addr = '0; ld_mask = '0; ld_tail = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state.
        check_eq("rst_enq_ready", 32'(enq_ready), 32'd1);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_stq_idx", 32'(enq_stq_idx), 32'd0);
        check_eq("rst_dmem_valid", 32'(dmem_valid), 32'd0);
        check_eq("rst_done_valid", 32'(done_valid), 32'd0);
        check_eq("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check_eq("rst_fwd_stall", 32'(fwd_stall), 32'd0);
        check_eq("rst_fwd_data", fwd_data[31:0] | fwd_data[63:32], 32'd0);

        // Fill to full.
        for (int i = 0; i < 8; i++) do_enq(5'(i));
        check_eq("full_count", 32'(count), 32'd8);
        check_eq("full_enq_ready", 32'(enq_ready), 32'd0);
        check_eq("full_stq_idx", 32'(enq_stq_idx), 32'd8);
        enq_valid = 1'b1; enq_rob_id = 5'd30;
        tick();
        enq_valid = 1'b0;
        check_eq("full_blocked_count", 32'(count), 32'd8);
        check_eq("full_blocked_idx", 32'(enq_stq_idx), 32'd8);

        for (int i = 0; i < 8; i++) do_fill(3'(i), 32'h1000 + 32'(4 * i) + 32'd1, 4'hF, 32'hA0 + 32'(i));

        // Drain in order; low address bits are forced to zero.
        dmem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rob_head_id = 5'(i);
            #1;
            check_eq($sformatf("drain%0d_valid", i), 32'(dmem_valid), 32'd1);
            check_eq($sformatf("drain%0d_addr", i), dmem_addr, 32'h1000 + 32'(4 * i));
            check_eq($sformatf("drain%0d_wdata", i), dmem_wdata, 32'hA0 + 32'(i));
            check_eq($sformatf("drain%0d_done", i), 32'(done_valid), 32'd1);
            check_eq($sformatf("drain%0d_rob", i), 32'(done_rob_id), 32'(i));
            if (i == 0) check_eq("drain0_ready_reg", 32'(enq_ready), 32'd0);
            tick();
        end
        rob_head_id = 5'd31;
        #1;
        check_eq("drained_count", 32'(count), 32'd0);
        check_eq("drained_enq_ready", 32'(enq_ready), 32'd1);
        check_eq("drained_dmem_valid", 32'(dmem_valid), 32'd0);

        // Wrap: 12 single-store enqueue/fill/drain rounds.
        for (int j = 0; j < 12; j++) begin
            check_eq($sformatf("wrap%0d_idx", j), 32'(enq_stq_idx), 32'((8 + j) % 16));
            do_enq(5'(8 + j));
            rob_head_id = 5'(8 + j);
            agu_valid = 1'b1; agu_idx = 3'((8 + j) % 8);
            agu_addr = 32'h2000 + 32'(4 * j); agu_mask = 4'hF; agu_wdata = 32'(j);
            #1;
            check_eq($sformatf("wrap%0d_nobypass", j), 32'(dmem_valid), 32'd0);
            tick();
            agu_valid = 1'b0;
            #1;
            check_eq($sformatf("wrap%0d_done", j), 32'(done_valid), 32'd1);
            check_eq($sformatf("wrap%0d_rob", j), 32'(done_rob_id), 32'(8 + j));
            tick();
            rob_head_id = 5'd31;
        end
        check_eq("wrap_end_idx", 32'(enq_stq_idx), 32'd4);
        check_eq("wrap_end_count", 32'(count), 32'd0);

        // Forwarding. rd_ptr = 4; A -> ptr 4, B -> ptr 5.
        dmem_ready = 1'b0;
        do_enq(5'd20);
        do_enq(5'd21);
        set_ld(0, 32'h100, 4'b0011, 4'd6);
        chk_probe("unk_both", 0, 1'b0, 1'b1, 32'h0);
        do_fill(3'd4, 32'h100, 4'hF, 32'hDEADBEEF);
        chk_probe("unk_b", 0, 1'b0, 1'b1, 32'h0);
        set_ld(0, 32'h100, 4'b0011, 4'd5);
        chk_probe("hit_a", 0, 1'b1, 1'b0, 32'hDEADBEEF);
        do_fill(3'd5, 32'h100, 4'b0011, 32'h0000CAFE);
        set_ld(0, 32'h100, 4'b0011, 4'd6);
        set_ld(1, 32'h100, 4'b1100, 4'd5);
        chk_probe("hit_b", 0, 1'b1, 1'b0, 32'h0000CAFE);
        chk_probe("hit_a_ch1", 1, 1'b1, 1'b0, 32'hDEADBEEF);
        set_ld(0, 32'h100, 4'b1100, 4'd6);
        chk_probe("partial", 0, 1'b0, 1'b1, 32'h0);
        set_ld(0, 32'h100, 4'b0011, 4'd4);
        chk_probe("tail_eq_rd", 0, 1'b0, 1'b0, 32'h0);

        // Unknown address, then filled at a different word. C -> ptr 6.
        do_enq(5'd22);
        set_ld(0, 32'h300, 4'hF, 4'd7);
        chk_probe("unk_c", 0, 1'b0, 1'b1, 32'h0);
        do_fill(3'd6, 32'h104, 4'b0001, 32'h11223344);
        chk_probe("c_other_word", 0, 1'b0, 1'b0, 32'h0);
        set_ld(1, 32'h104, 4'b0001, 4'd7);
        chk_probe("hit_c_ch1", 1, 1'b1, 1'b0, 32'h11223344);
        ld_valid = '0;
        #1;
        chk_probe("idle_ch0", 0, 1'b0, 1'b0, 32'h0);
        chk_probe("idle_ch1", 1, 1'b0, 1'b0, 32'h0);

        // Drain A and B, leaving C at rd_ptr 6.
        dmem_ready = 1'b1;
        rob_head_id = 5'd20;
        #1;
        check_eq("drain_a_rob", 32'(done_rob_id), 32'd20);
        check_eq("drain_a_done", 32'(done_valid), 32'd1);
        tick();
        rob_head_id = 5'd21;
        #1;
        check_eq("drain_b_rob", 32'(done_rob_id), 32'd21);
        check_eq("drain_b_wmask", 32'(dmem_wmask), 32'h3);
        tick();
        dmem_ready = 1'b0;
        rob_head_id = 5'd31;
        #1;
        check_eq("post_ab_count", 32'(count), 32'd1);
        set_ld(0, 32'h100, 4'b0011, 4'd5);
        chk_probe("stale_tail", 0, 1'b0, 1'b0, 32'h0);
        set_ld(0, 32'h104, 4'b0001, 4'd7);
        chk_probe("post_ab_hit_c", 0, 1'b1, 1'b0, 32'h11223344);
        ld_valid = '0;

        // Flush with 5 entries and the head waiting on dmem_ready.
        for (int i = 0; i < 4; i++) do_enq(5'(23 + i));
        check_eq("pre_flush_count", 32'(count), 32'd5);
        rob_head_id = 5'd22;
        #1;
        check_eq("pre_flush_dmem_valid", 32'(dmem_valid), 32'd1);
        flush = 1'b1;
        enq_valid = 1'b1; enq_rob_id = 5'd27;
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        #1;
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_dmem_valid", 32'(dmem_valid), 32'd0);
        check_eq("flush_enq_ready", 32'(enq_ready), 32'd1);
        check_eq("flush_stq_idx", 32'(enq_stq_idx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stq_fwd.md
# stq_fwd

Parametrised store queue with store-to-load forwarding, the next generation of the backend store queue. It sits between dispatch, the AGU, the ROB and the data-cache write port. It allocates store entries in program order and fills address/data by direct index from the AGU. It drains to dmem only when the store is at the ROB head. It resolves NUM_LD concurrent load probes against older in-flight stores, returning hit (forward data), stall (unresolvable conflict) or clear.

## Interface
- DEPTH, 8: entries; power of two, >= 2. IDX = $clog2(DEPTH); PW = IDX+1 (pointer width, MSB = wrap flag).
- ROB_ID_W, 5: ROB id width.
- NUM_LD, 2: load probe channels.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  backend flush; discards every entry.
- enq_valid / enq_ready  in / out  1 / 1  dispatch handshake; enq_ready = ~full.
- enq_rob_id  in  ROB_ID_W  ROB id of the allocated store.
- enq_stq_idx  out  PW  current wr_ptr, the index handed to the store uop.
- agu_valid  in  1  address/data fill.
- agu_idx  in  IDX  target entry.
- agu_addr, agu_mask, agu_wdata  in  32, 4, 32  store payload.
- rob_head_id  in  ROB_ID_W  id of the ROB head.
- dmem_valid / dmem_ready  out / in  1 / 1  cache write handshake.
- dmem_addr, dmem_wmask, dmem_wdata  out  32, 4, 32  head entry; addr[1:0] forced to 0.
- done_valid, done_rob_id  out  1, ROB_ID_W  store-complete pulse to the ROB.
- count  out  PW  occupancy.
- ld_valid  in  NUM_LD  probe valid per channel.
- ld_addr  in  NUM_LD*32  probe address.
- ld_mask  in  NUM_LD*4  probe byte mask.
- ld_tail  in  NUM_LD*PW  wr_ptr snapshot taken at load dispatch.
- fwd_hit, fwd_stall  out  NUM_LD each  probe result.
- fwd_data  out  NUM_LD*32  forwarded word.

## Operation
- Entry fields: rob_id, addr_valid, addr, mask, wdata.
- Enqueue = enq_valid & enq_ready.
  - Writes rob_id into entry wr_ptr[IDX-1:0] and clears its addr_valid.
  - Increments wr_ptr and count.
- AGU fill writes addr, mask, wdata and sets addr_valid at entry agu_idx.
  - Ignored if the entry is not occupied, i.e. not in [rd_ptr, wr_ptr).
  - If enqueue targets the same entry in the same cycle, enqueue wins.
- Drain: want = ~empty & head.addr_valid & (head.rob_id == rob_head_id).
  - dmem_valid = want.
  - dequeue = want & dmem_ready; it increments rd_ptr and decrements count.
- done_valid = dequeue; done_rob_id = head.rob_id.
- Empty: wr_ptr == rd_ptr. Full: low bits equal and flags differ. Pointers wrap mod 2^PW.
- Probe, per channel i with ld_valid[i]:
  - Older set: entries at offsets 0 .. n-1 from rd_ptr, where n = (ld_tail - rd_ptr) mod 2^PW.
  - If n > count (the stores have already drained), n = 0.
  - fwd_stall = 1 if any older entry has addr_valid = 0.
  - Otherwise take M, the youngest older entry whose addr[31:2] == ld_addr[31:2]:
    - M exists and (M.mask & ld_mask) == ld_mask: fwd_hit = 1, fwd_data = M.wdata.
    - M exists but does not cover ld_mask: fwd_stall = 1.
    - No M: both 0.
  - fwd_hit and fwd_stall are never both 1.
  - All probe outputs are 0 when ld_valid[i] = 0.
- Flush and rst: rd_ptr = wr_ptr = count = 0 and all addr_valid cleared. Flush overrides same-cycle enqueue, fill and dequeue.

## Timing
- Reset values:
  - enq_ready = 1.
  - enq_stq_idx = 0, count = 0.
  - dmem_valid = 0, done_valid = 0.
  - fwd_hit = fwd_stall = fwd_data = 0.
- Enqueue and fill take effect at the next edge. A filled head can issue to dmem the cycle after the fill; there is no same-cycle fill-to-drain bypass.
- Probes are purely combinational on registered state plus the ld_* inputs. A fill in cycle t is visible to probes in cycle t+1.
- enq_ready depends only on registered full, never on a same-cycle dequeue.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal at full only for the dequeue; enqueue is blocked.
- dmem_valid may drop if rob_head_id changes; no hold requirement while dmem_ready = 0.
- Throughput: 1 enqueue and 1 dequeue per cycle.

## Test plan
- Reset, then idle -> enq_ready = 1, count = 0, dmem_valid = 0, all fwd outputs 0.
- Fill to full:
  - Enqueue 8 stores (rob 0..7) -> enq_ready = 0, count = 8.
  - Fill each, drive rob_head_id 0..7 with dmem_ready = 1 -> 8 done pulses in order, then enq_ready = 1.
  - Wrap: 12 more enq/deq -> pointer flag toggles, no lost or duplicated done_rob_id.
- Forward hit:
  - Store A at 0x100, mask 1111, data 0xDEADBEEF; later store B at 0x100, mask 0011, data 0x0000CAFE.
  - Load 0x100, mask 0011, tail after B -> fwd_hit = 1, fwd_data = 0x0000CAFE.
  - Same load with mask 1100 -> fwd_stall = 1 (youngest match does not cover).
- Unknown address: older store has no AGU fill yet -> fwd_stall = 1. After the fill at a different word -> hit = 0, stall = 0.
- Tail semantics:
  - Load with tail = rd_ptr -> no conflict even with a matching younger store.
  - Load whose older stores all drained (n > count) -> hit = 0, stall = 0.
- Flush mid-drain with dmem_ready = 0 and 5 entries -> next cycle count = 0, dmem_valid = 0, enq_ready = 1. Same-cycle enq_valid is dropped.
